// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the floating-point compare/min-max/classify pipeline.
// Op codes, FCLASS bit positions and the canonical quiet NaN.
package fp_cmp_pkg;

  localparam logic [2:0] OP_FEQ    = 3'd0;
  localparam logic [2:0] OP_FLT    = 3'd1;
  localparam logic [2:0] OP_FLE    = 3'd2;
  localparam logic [2:0] OP_FMIN   = 3'd3;
  localparam logic [2:0] OP_FMAX   = 3'd4;
  localparam logic [2:0] OP_FCLASS = 3'd5;

  localparam int CLS_NEG_INF  = 0;
  localparam int CLS_NEG_NORM = 1;
  localparam int CLS_NEG_SUB  = 2;
  localparam int CLS_NEG_ZERO = 3;
  localparam int CLS_POS_ZERO = 4;
  localparam int CLS_POS_SUB  = 5;
  localparam int CLS_POS_NORM = 6;
  localparam int CLS_POS_INF  = 7;
  localparam int CLS_SNAN     = 8;
  localparam int CLS_QNAN     = 9;
  localparam int CLS_BITS     = 10;

  localparam int MAX_W = 64;

  // Positive sign, exponent all-ones, only the fraction MSB set.
  function automatic logic [MAX_W-1:0] canonical_nan(input int exp_w, input int sig_w);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i >= sig_w && i < sig_w + exp_w) v[i] = 1'b1;
      if (i == sig_w - 1) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/fp_cmp_core.sv
// Combinational classify, compare and min/max select for one FP op.
// Produces the full-width result and the invalid-operation flag.
module fp_cmp_core
  import fp_cmp_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_result,
  output logic         o_nv
);

  localparam logic [MAX_W-1:0] CNAN_FULL = canonical_nan(EXP_WIDTH, SIG_WIDTH);
  localparam logic [W-1:0]     CNAN      = CNAN_FULL[W-1:0];

  logic                 w_sign_a, w_sign_b;
  logic [EXP_WIDTH-1:0] w_exp_a, w_exp_b;
  logic [SIG_WIDTH-1:0] w_frac_a, w_frac_b;
  logic [W-2:0]         w_mag_a, w_mag_b;

  assign w_sign_a = i_a[W-1];
  assign w_sign_b = i_b[W-1];
  assign w_exp_a  = i_a[W-2 -: EXP_WIDTH];
  assign w_exp_b  = i_b[W-2 -: EXP_WIDTH];
  assign w_frac_a = i_a[SIG_WIDTH-1:0];
  assign w_frac_b = i_b[SIG_WIDTH-1:0];
  assign w_mag_a  = i_a[W-2:0];
  assign w_mag_b  = i_b[W-2:0];

  logic w_nan_a, w_snan_a, w_qnan_a, w_inf_a, w_zero_a, w_sub_a, w_norm_a;
  logic w_nan_b, w_snan_b, w_zero_b;

  assign w_nan_a  = (&w_exp_a) & (|w_frac_a);
  assign w_snan_a = w_nan_a & ~w_frac_a[SIG_WIDTH-1];
  assign w_qnan_a = w_nan_a & w_frac_a[SIG_WIDTH-1];
  assign w_inf_a  = (&w_exp_a) & ~(|w_frac_a);
  assign w_zero_a = ~(|w_exp_a) & ~(|w_frac_a);
  assign w_sub_a  = ~(|w_exp_a) & (|w_frac_a);
  assign w_norm_a = ~(&w_exp_a) & (|w_exp_a);

  assign w_nan_b  = (&w_exp_b) & (|w_frac_b);
  assign w_snan_b = w_nan_b & ~w_frac_b[SIG_WIDTH-1];
  assign w_zero_b = ~(|w_exp_b) & ~(|w_frac_b);

  // Total order with -0 below +0 drives min/max; the numeric compare then treats zeros as equal.
  logic w_lt_tot, w_lt, w_eq, w_both_zero, w_any_nan, w_any_snan;

  assign w_both_zero = w_zero_a & w_zero_b;
  assign w_lt_tot    = (w_sign_a != w_sign_b) ? w_sign_a :
                       (w_sign_a ? (w_mag_b < w_mag_a) : (w_mag_a < w_mag_b));
  assign w_lt        = w_lt_tot & ~w_both_zero;
  assign w_eq        = (i_a == i_b) | w_both_zero;
  assign w_any_nan   = w_nan_a | w_nan_b;
  assign w_any_snan  = w_snan_a | w_snan_b;

  logic [CLS_BITS-1:0] w_cls;

  always_comb begin
    w_cls               = '0;
    w_cls[CLS_NEG_INF]  = w_sign_a & w_inf_a;
    w_cls[CLS_NEG_NORM] = w_sign_a & w_norm_a;
    w_cls[CLS_NEG_SUB]  = w_sign_a & w_sub_a;
    w_cls[CLS_NEG_ZERO] = w_sign_a & w_zero_a;
    w_cls[CLS_POS_ZERO] = ~w_sign_a & w_zero_a;
    w_cls[CLS_POS_SUB]  = ~w_sign_a & w_sub_a;
    w_cls[CLS_POS_NORM] = ~w_sign_a & w_norm_a;
    w_cls[CLS_POS_INF]  = ~w_sign_a & w_inf_a;
    w_cls[CLS_SNAN]     = w_snan_a;
    w_cls[CLS_QNAN]     = w_qnan_a;
  end

  always_comb begin
    o_result = '0;
    o_nv     = 1'b0;
    case (i_op)
      OP_FEQ: begin
        o_result[0] = ~w_any_nan & w_eq;
        o_nv        = w_any_snan;
      end
      OP_FLT: begin
        o_result[0] = ~w_any_nan & w_lt;
        o_nv        = w_any_nan;
      end
      OP_FLE: begin
        o_result[0] = ~w_any_nan & (w_lt | w_eq);
        o_nv        = w_any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        o_nv = w_any_snan;
        if (w_nan_a & w_nan_b)      o_result = CNAN;
        else if (w_nan_a)           o_result = i_b;
        else if (w_nan_b)           o_result = i_a;
        else if (i_op == OP_FMIN)   o_result = w_lt_tot ? i_a : i_b;
        else                        o_result = w_lt_tot ? i_b : i_a;
      end
      OP_FCLASS: begin
        o_result[CLS_BITS-1:0] = w_cls;
      end
      default: begin
        o_result = '0;
        o_nv     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fp_cmp_pipe.sv
// Pipelined FP compare/min-max/classify unit with valid/ready handshake.
// All evaluation happens ahead of stage 0; later slices only carry results and tags.
module fp_cmp_pipe
  import fp_cmp_pkg::*;
#(
  parameter int SIG_WIDTH = 23,
  parameter int EXP_WIDTH = 8,
  parameter int STAGES    = 2,
  parameter int TAG_WIDTH = 5,
  localparam int W = SIG_WIDTH + EXP_WIDTH + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [W-1:0]         in_a,
  input  logic [W-1:0]         in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_result,
  output logic                 out_nv,
  output logic [TAG_WIDTH-1:0] out_tag
);

  logic [W-1:0] w_result;
  logic         w_nv;

  fp_cmp_core #(
    .SIG_WIDTH(SIG_WIDTH),
    .EXP_WIDTH(EXP_WIDTH)
  ) u_core (
    .i_a      (in_a),
    .i_b      (in_b),
    .i_op     (in_op),
    .o_result (w_result),
    .o_nv     (w_nv)
  );

  logic                 w_v   [STAGES];
  logic                 w_adv [STAGES];
  logic [W-1:0]         w_res [STAGES];
  logic                 w_flg [STAGES];
  logic [TAG_WIDTH-1:0] w_tag [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic                 w_in_v;
    logic [W-1:0]         w_in_res;
    logic                 w_in_nv;
    logic [TAG_WIDTH-1:0] w_in_tag;
    logic                 r_v;
    logic [W-1:0]         r_res;
    logic                 r_nv;
    logic [TAG_WIDTH-1:0] r_tag;

    if (g == 0) begin : g_head
      assign w_in_v   = in_valid;
      assign w_in_res = w_result;
      assign w_in_nv  = w_nv;
      assign w_in_tag = in_tag;
    end else begin : g_body
      assign w_in_v   = w_v[g-1];
      assign w_in_res = w_res[g-1];
      assign w_in_nv  = w_flg[g-1];
      assign w_in_tag = w_tag[g-1];
    end

    // A slice may take new data when empty, so bubbles collapse under a stalled tail.
    if (g == STAGES - 1) begin : g_tail
      assign w_adv[g] = ~r_v | out_ready;
    end else begin : g_mid
      assign w_adv[g] = ~r_v | w_adv[g+1];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v   <= 1'b0;
        r_res <= '0;
        r_nv  <= 1'b0;
        r_tag <= '0;
      end else begin
        if (flush)          r_v <= 1'b0;
        else if (w_adv[g])  r_v <= w_in_v;
        if (w_adv[g] && w_in_v) begin
          r_res <= w_in_res;
          r_nv  <= w_in_nv;
          r_tag <= w_in_tag;
        end
      end
    end

    assign w_v[g]   = r_v;
    assign w_res[g] = r_res;
    assign w_flg[g] = r_nv;
    assign w_tag[g] = r_tag;
  end

  assign in_ready   = w_adv[0];
  assign out_valid  = w_v[STAGES-1];
  assign out_result = w_res[STAGES-1];
  assign out_nv     = w_flg[STAGES-1];
  assign out_tag    = w_tag[STAGES-1];

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Self-checking bench for fp_cmp_pipe: directed test-plan vectors plus a randomized
// stream scored against a real-arithmetic reference model and an occupancy/timing model.
module tb_fp_cmp_pipe;

  parameter int STAGES = 2;
  localparam int SW = 23;
  localparam int EW = 8;
  localparam int TW = 5;
  localparam int W  = SW + EW + 1;
  localparam int BIAS = (1 << (EW - 1)) - 1;
  localparam logic [W-1:0] CNAN = 32'h7FC0_0000;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_nv;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_result;
  logic [TW-1:0] in_tag, out_tag;

  always #5 clk = ~clk;

  fp_cmp_pipe #(
    .SIG_WIDTH(SW), .EXP_WIDTH(EW), .STAGES(STAGES), .TAG_WIDTH(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_nv(out_nv), .out_tag(out_tag)
  );

  typedef struct packed { logic [W-1:0] res; logic nv; } ref_t;
  typedef struct { logic [W-1:0] res; logic nv; logic [TW-1:0] tag; int acc; } item_t;

  item_t         q[$];
  int            n_vec = 0, n_err = 0;
  int            cyc = 0, last_dep = -100;
  bit            popped, accepted, last_ir;
  logic [W-1:0]  obs_res;
  logic          obs_nv;
  logic [TW-1:0] obs_tag;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_nan(input logic [W-1:0] x);
    return (x[W-2 -: EW] == {EW{1'b1}}) && (x[SW-1:0] != '0);
  endfunction

  function automatic bit is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[SW-1];
  endfunction

  function automatic real to_real(input logic [W-1:0] x);
    int  e;
    real m, v;
    e = int'(x[W-2 -: EW]);
    m = real'(x[SW-1:0]) / (2.0 ** SW);
    if (e == 0) v = m * (2.0 ** (1 - BIAS));
    else        v = (1.0 + m) * (2.0 ** (e - BIAS));
    return x[W-1] ? -v : v;
  endfunction

  function automatic ref_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    ref_t r;
    real  ra, rb;
    bit   na, nb, sn;
    int   idx;
    r  = '0;
    ra = to_real(a);
    rb = to_real(b);
    na = is_nan(a);
    nb = is_nan(b);
    sn = is_snan(a) || is_snan(b);
    case (op)
      3'd0: begin r.res = W'(!na && !nb && ra == rb); r.nv = sn; end
      3'd1: begin r.res = W'(!na && !nb && ra <  rb); r.nv = na || nb; end
      3'd2: begin r.res = W'(!na && !nb && ra <= rb); r.nv = na || nb; end
      3'd3, 3'd4: begin
        r.nv = sn;
        if (na && nb)      r.res = CNAN;
        else if (na)       r.res = b;
        else if (nb)       r.res = a;
        else if (ra < rb)  r.res = (op == 3'd3) ? a : b;
        else if (rb < ra)  r.res = (op == 3'd3) ? b : a;
        else if (op == 3'd3) r.res = a[W-1] ? a : b;
        else                 r.res = a[W-1] ? b : a;
      end
      3'd5: begin
        if (na)                                idx = is_snan(a) ? 8 : 9;
        else if (a[W-2 -: EW] == {EW{1'b1}})   idx = a[W-1] ? 0 : 7;
        else if (ra == 0.0)                    idx = a[W-1] ? 3 : 4;
        else if (a[W-2 -: EW] == '0)           idx = a[W-1] ? 2 : 5;
        else                                   idx = a[W-1] ? 1 : 6;
        r.res = W'(1) << idx;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_fp();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 9))
      0: return {s, 31'h0};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 8'hFF, 1'b1, 22'($urandom)};
      3: return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
      4: return {s, 8'h00, 23'($urandom) | 23'h1};
      5: return {s, 8'd127, 23'h0};
      default: return 32'($urandom);
    endcase
  endfunction

  // One clock: check handshake/timing/data against the models, then let the edge happen.
  task automatic tick();
    item_t it;
    ref_t  r;
    logic  exp_ov;
    #1;
    popped   = 0;
    accepted = 0;
    last_ir  = in_ready;
    chk("in_ready", W'(in_ready), W'((q.size() < STAGES) || out_ready));
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (cyc >= q[0].acc + STAGES) && (cyc >= last_dep + 1);
    chk("out_valid", W'(out_valid), W'(exp_ov));
    if (out_valid && q.size() > 0) begin
      chk("result", out_result, q[0].res);
      chk("nv", W'(out_nv), W'(q[0].nv));
      chk("tag", W'(out_tag), W'(q[0].tag));
      if (out_ready) begin
        it       = q.pop_front();
        popped   = 1;
        obs_res  = out_result;
        obs_nv   = out_nv;
        obs_tag  = out_tag;
        last_dep = cyc;
      end
    end
    if (!rst_n || flush) begin
      q.delete();
    end else if (in_valid && in_ready) begin
      r      = model(in_op, in_a, in_b);
      it.res = r.res;
      it.nv  = r.nv;
      it.tag = in_tag;
      it.acc = cyc;
      q.push_back(it);
      accepted = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_one(input string name, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res, input logic exp_nv);
    int c0;
    logic [TW-1:0] tg;
    tg        = TW'($urandom);
    in_valid  = 1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_tag    = tg;
    out_ready = 1;
    flush     = 0;
    c0        = cyc;
    for (int k = 0; k < 20 && !accepted; k++) begin c0 = cyc; tick(); end
    in_valid = 0;
    popped   = 0;
    for (int k = 0; k < 20 && !popped; k++) tick();
    chk({name, "_done"}, W'(popped), W'(1));
    chk({name, "_lat"}, W'(last_dep - c0), W'(STAGES));
    chk({name, "_res"}, obs_res, exp_res);
    chk({name, "_nv"}, W'(obs_nv), W'(exp_nv));
    chk({name, "_tag"}, W'(obs_tag), W'(tg));
  endtask

  task automatic drain();
    in_valid  = 0;
    flush     = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && q.size() > 0; k++) tick();
    chk("drain", W'(q.size()), W'(0));
  endtask

  initial begin
    logic [W-1:0] va[8], vb[8];
    int           idx;
    bit           saw_full;

    rst_n = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_result", out_result, '0);
    chk("rst_nv", W'(out_nv), W'(0));
    chk("rst_tag", W'(out_tag), W'(0));
    rst_n = 1;
    #1 chk("rst_in_ready", W'(in_ready), W'(1));
    @(negedge clk);

    accepted = 0;
    run_one("flt",      3'd1, 32'hBF80_0000, 32'h3F80_0000, 32'h1, 1'b0);
    accepted = 0;
    run_one("feq_z",    3'd0, 32'h8000_0000, 32'h0000_0000, 32'h1, 1'b0);
    accepted = 0;
    run_one("fmin_z",   3'd3, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    accepted = 0;
    run_one("fmax_z",   3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    accepted = 0;
    run_one("fmax_sn",  3'd4, 32'h7F80_0001, 32'h4000_0000, 32'h4000_0000, 1'b1);
    accepted = 0;
    run_one("fmin_qq",  3'd3, 32'h7FC0_0001, 32'h7FC0_0001, 32'h7FC0_0000, 1'b0);
    accepted = 0;
    run_one("fle_qn",   3'd2, 32'h7FC0_0000, 32'h0000_0000, 32'h0, 1'b1);
    accepted = 0;
    run_one("fle_zz",   3'd2, 32'h8000_0000, 32'h0000_0000, 32'h1, 1'b0);
    accepted = 0;
    run_one("cls_ninf", 3'd5, 32'hFF80_0000, 32'h0, 32'h001, 1'b0);
    accepted = 0;
    run_one("cls_psub", 3'd5, 32'h0000_0001, 32'h0, 32'h020, 1'b0);
    accepted = 0;
    run_one("cls_qnan", 3'd5, 32'h7FC0_0000, 32'h0, 32'h200, 1'b0);
    accepted = 0;
    run_one("rsvd",     3'd6, 32'h3F80_0000, 32'h3F80_0000, 32'h0, 1'b0);

    // Back-to-back burst with a three-cycle consumer stall.
    for (int i = 0; i < 8; i++) begin va[i] = rnd_fp(); vb[i] = rnd_fp(); end
    idx = 0;
    saw_full = 0;
    for (int k = 0; k < 40 && (idx < 8 || q.size() > 0); k++) begin
      in_valid  = (idx < 8);
      in_op     = 3'(idx % 6);
      in_a      = va[idx % 8];
      in_b      = vb[idx % 8];
      in_tag    = TW'(idx + 8);
      out_ready = !(k >= 3 && k < 6);
      tick();
      if (!last_ir) saw_full = 1;
      if (accepted) idx++;
    end
    chk("b2b_sent", W'(idx), W'(8));
    chk("b2b_full", W'(saw_full), W'(1));
    drain();

    // Randomized traffic with random back-pressure.
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = rnd_fp();
      in_b      = ($urandom_range(0, 3) == 0) ? in_a :
                  ($urandom_range(0, 7) == 0) ? {~in_a[W-1], in_a[W-2:0]} : rnd_fp();
      in_tag    = TW'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    // Flush with ops in flight and a competing request.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_op = 3'd4; in_a = 32'h4000_0000; in_b = 32'h3F80_0000;
      in_tag = TW'(k + 3); out_ready = 0;
      tick();
    end
    flush = 1; in_valid = 1; in_tag = 5'h1F;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    for (int k = 0; k < STAGES + 2; k++) tick();
    chk("flush_empty", W'(out_valid), W'(0));
    chk("flush_ready", W'(in_ready), W'(1));

    // Reset mid-operation also clears the output data.
    for (int k = 0; k < 2; k++) begin
      in_valid = 1; in_op = 3'd4; in_a = 32'h4000_0000; in_b = 32'h3F80_0000;
      in_tag = TW'(k + 5); out_ready = 0;
      tick();
    end
    rst_n = 0; in_valid = 1;
    tick();
    rst_n = 1; in_valid = 0; out_ready = 1;
    #1;
    chk("mrst_valid", W'(out_valid), W'(0));
    chk("mrst_result", out_result, '0);
    chk("mrst_nv", W'(out_nv), W'(0));
    chk("mrst_tag", W'(out_tag), W'(0));
    @(negedge clk);
    for (int k = 0; k < 3; k++) tick();

    accepted = 0;
    run_one("post_rst", 3'd1, 32'h3F80_0000, 32'hBF80_0000, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
